mdu_hilo_seq: RTL
=================

Name: mdu_hilo_seq

Overview:
- Sequential multiply/divide controller sitting around the combinational Booth multiplier in the datapath.
- Latches operands from the bus and drives them to the multiplier.
- Captures the 64-bit product after a fixed settle time, or runs a 32-iteration signed restoring division internally.
- Holds the result in the Z pair (z_hi/z_lo), which the datapath later moves to HI/LO.

Parameters:
- WIDTH, 32, operand width; results are 2*WIDTH split across z_hi/z_lo.
- MUL_LAT, 1, cycles the multiplier output is given to settle before capture (≥1).

Ports:
- clock  in  1  system clock, rising edge
- clear  in  1  asynchronous active-high reset
- start  in  1  request; sampled only in IDLE
- op  in  2  00 = MUL, 01 = DIV; 10/11 illegal
- a  in  WIDTH  operand A (multiplicand / dividend), signed
- b  in  WIDTH  operand B (multiplier / divisor), signed
- mul_x  out  WIDTH  latched A, to multiplier x input
- mul_y  out  WIDTH  latched B, to multiplier y input
- mul_product  in  2*WIDTH  multiplier result
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- div_by_zero  out  1  sticky flag for the last DIV, set when divisor was 0
- z_hi  out  WIDTH  MUL: product[63:32]; DIV: remainder
- z_lo  out  WIDTH  MUL: product[31:0]; DIV: quotient

Behaviour:
- Reset (clear=1, async):
  - All outputs and internal registers go to 0; state = IDLE.
  - An operation in flight is abandoned with no done pulse.
- States: IDLE, MUL_WAIT, DIV_RUN, DIV_FIX, DONE.
- Edge E0 = the rising edge where IDLE samples start=1 with a legal op.
  - At E0: a→mul_x and b→mul_y (these hold until the next accepted start); busy=1.
- Illegal op: start is ignored; state remains IDLE; no done pulse; z unchanged.
- start in any state other than IDLE: ignored.
- MUL path:
  - IDLE→MUL_WAIT; count down MUL_LAT cycles.
  - At edge E0+MUL_LAT+1: z_hi/z_lo ← mul_product; div_by_zero←0; done=1; busy=0; state=DONE.
- DIV path, divisor ≠ 0:
  - At E0: latch |a| and |b| as unsigned magnitudes, plus the signs; remainder accumulator←0; iteration counter←0; → DIV_RUN.
  - DIV_RUN, one iteration per cycle, WIDTH cycles:
    - shift {rem, quo} left by 1;
    - trial = rem − |b|;
    - if trial ≥ 0 then rem←trial and quo[0]←1.
  - DIV_FIX, 1 cycle:
    - quotient negated if sign(a)≠sign(b);
    - remainder negated if a<0 (truncation toward zero; remainder takes the dividend's sign).
  - At edge E0+WIDTH+2: z updated; div_by_zero←0; done=1; busy=0.
- DIV path, divisor = 0:
  - At E0+1: z_lo←all ones, z_hi←a, div_by_zero←1; done=1; busy=0; no iterations run.
- Overflow: a = 0x80000000, b = −1 gives quotient 0x80000000 and remainder 0, which falls out of the magnitude arithmetic with no special case.
- DONE: done is high for exactly one cycle, then the next edge returns to IDLE.
  - A start asserted during DONE is ignored; earliest acceptance is the cycle after done.
- z_hi, z_lo and div_by_zero hold their values until the next completion or reset.
- busy is high from E0 up to, but not including, the done cycle; busy and done are never both high.

Test Plan:
- Reset then MUL, a=7, b=0xFFFFFFFD (−3), MUL_LAT=1, bench multiplier attached → at E0+2: done=1, z_hi=0xFFFFFFFF, z_lo=0xFFFFFFEB, busy=0; at E0+3: done=0.
- MUL, a=b=0x80000000 → z_hi=0x40000000, z_lo=0x00000000; mul_x and mul_y read 0x80000000 from E0+1 onward.
- DIV, a=0xFFFFFFF9 (−7), b=2 → at E0+34: z_lo=0xFFFFFFFD (−3), z_hi=0xFFFFFFFF (−1), div_by_zero=0; busy high for 34 cycles.
- DIV a=5, b=0 → at E0+1: z_lo=0xFFFFFFFF, z_hi=5, div_by_zero=1. Then DIV a=0x80000000, b=0xFFFFFFFF → z_lo=0x80000000, z_hi=0, div_by_zero=0.
- During a DIV, pulse start with op=MUL at cycle E0+5; separately, pulse start with op=11 while IDLE → both ignored; the DIV result is unchanged and exactly one done pulse occurs.
- Assert clear asynchronously mid-DIV at E0+10 → busy, done, z_hi, z_lo, mul_x and mul_y read 0 immediately; no done pulse follows; a new MUL started after release completes normally.

Source files
------------

// File: rtl/mdu_hilo_seq.sv
// -----------------------------------------------------------------------------
// mdu_hilo_seq
//   Sequential multiply/divide controller wrapped around the datapath's
//   combinational Booth multiplier. Operands are latched from the bus and
//   driven to the multiplier. A MUL captures the 64-bit product after a fixed
//   settle time. A DIV runs a signed restoring division internally, one
//   quotient bit per cycle. The result is held in the Z pair (z_hi/z_lo) until
//   the datapath moves it to HI/LO.
//
// Ports
//   clock        in   rising-edge system clock
//   clear        in   asynchronous active-high reset
//   start        in   operation request, sampled only while idle
//   op           in   2'b00 = MUL, 2'b01 = DIV, other codes are ignored
//   a, b         in   signed operands (multiplicand/dividend, multiplier/divisor)
//   mul_x, mul_y out  latched operands driven to the multiplier
//   mul_product  in   multiplier result
//   busy         out  operation in progress (low during the done cycle)
//   done         out  one-cycle completion pulse
//   div_by_zero  out  set by a DIV whose divisor was zero, cleared by any
//                     other completion
//   z_hi         out  MUL: product high half, DIV: remainder
//   z_lo         out  MUL: product low half,  DIV: quotient
// -----------------------------------------------------------------------------
module mdu_hilo_seq #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 1
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [WIDTH-1:0]     mul_x,
    output logic [WIDTH-1:0]     mul_y,
    input  logic [2*WIDTH-1:0]   mul_product,
    output logic                 busy,
    output logic                 done,
    output logic                 div_by_zero,
    output logic [WIDTH-1:0]     z_hi,
    output logic [WIDTH-1:0]     z_lo
);

    localparam int IW = $clog2(WIDTH + 1);
    localparam int MW = $clog2(MUL_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MUL_WAIT = 3'd1,
        S_DIV_RUN  = 3'd2,
        S_DIV_FIX  = 3'd3,
        S_DONE     = 3'd4
    } state_e;

    // Two's-complement negation when n is set, pass-through otherwise.
    function automatic logic [WIDTH-1:0] neg_if(input logic n, input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if (n) begin
            r = {WIDTH{1'b0}} - v;
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_e            state_q, state_d;
    logic [MW-1:0]     mcnt_q, mcnt_d;
    logic [IW-1:0]     iter_q, iter_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic [WIDTH-1:0]  quo_q, quo_d;
    logic [WIDTH-1:0]  bmag_q, bmag_d;
    logic              sign_a_q, sign_a_d;
    logic              sign_q_q, sign_q_d;
    logic              dz_q, dz_d;
    logic [WIDTH-1:0]  x_q, x_d;
    logic [WIDTH-1:0]  y_q, y_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              dbz_q, dbz_d;
    logic [WIDTH-1:0]  zhi_q, zhi_d;
    logic [WIDTH-1:0]  zlo_q, zlo_d;

    logic              op_legal_s;
    logic [WIDTH:0]    rem_sh_s;
    logic              rem_ge_s;
    logic [WIDTH-1:0]  rem_sub_s;

    // Restoring-division step: shift {rem, quo} left, trial-subtract |b|.
    // rem < |b| <= 2^(WIDTH-1), so the shifted remainder never reaches bit
    // WIDTH and the WIDTH-bit subtraction is exact whenever it is taken.
    assign op_legal_s = (op == 2'b00) || (op == 2'b01);
    assign rem_sh_s   = {rem_q, quo_q[WIDTH-1]};
    assign rem_ge_s   = (rem_sh_s >= {1'b0, bmag_q});
    assign rem_sub_s  = rem_sh_s[WIDTH-1:0] - bmag_q;

    // Next-state and datapath register updates for every controller state.
    always_comb begin
        state_d  = state_q;
        mcnt_d   = mcnt_q;
        iter_d   = iter_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        bmag_d   = bmag_q;
        sign_a_d = sign_a_q;
        sign_q_d = sign_q_q;
        dz_d     = dz_q;
        x_d      = x_q;
        y_d      = y_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dbz_d    = dbz_q;
        zhi_d    = zhi_q;
        zlo_d    = zlo_q;

        case (state_q)
            S_IDLE: begin
                if (start && op_legal_s) begin
                    x_d    = a;
                    y_d    = b;
                    busy_d = 1'b1;
                    if (op == 2'b00) begin
                        mcnt_d  = MW'(MUL_LAT);
                        state_d = S_MUL_WAIT;
                    end else begin
                        // Division works on magnitudes; signs are reapplied in DIV_FIX.
                        quo_d    = neg_if(a[WIDTH-1], a);
                        bmag_d   = neg_if(b[WIDTH-1], b);
                        rem_d    = {WIDTH{1'b0}};
                        iter_d   = {IW{1'b0}};
                        sign_a_d = a[WIDTH-1];
                        sign_q_d = a[WIDTH-1] ^ b[WIDTH-1];
                        dz_d     = (b == {WIDTH{1'b0}});
                        state_d  = S_DIV_RUN;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_MUL_WAIT: begin
                if (mcnt_q == {MW{1'b0}}) begin
                    zhi_d   = mul_product[2*WIDTH-1:WIDTH];
                    zlo_d   = mul_product[WIDTH-1:0];
                    dbz_d   = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    mcnt_d = mcnt_q - MW'(1'b1);
                end
            end

            S_DIV_RUN: begin
                if (dz_q) begin
                    // Zero divisor: no iterations, dividend reported as remainder.
                    zhi_d   = x_q;
                    zlo_d   = {WIDTH{1'b1}};
                    dbz_d   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end else if (iter_q == IW'(WIDTH)) begin
                    // Terminal-count cycle after the last quotient bit.
                    state_d = S_DIV_FIX;
                end else begin
                    if (rem_ge_s) begin
                        rem_d = rem_sub_s;
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = rem_sh_s[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    iter_d = iter_q + IW'(1'b1);
                end
            end

            S_DIV_FIX: begin
                // Truncating division: remainder follows the dividend's sign.
                zlo_d   = neg_if(sign_q_q, quo_q);
                zhi_d   = neg_if(sign_a_q, rem_q);
                dbz_d   = 1'b0;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_DONE;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            mcnt_q   <= {MW{1'b0}};
            iter_q   <= {IW{1'b0}};
            rem_q    <= {WIDTH{1'b0}};
            quo_q    <= {WIDTH{1'b0}};
            bmag_q   <= {WIDTH{1'b0}};
            sign_a_q <= 1'b0;
            sign_q_q <= 1'b0;
            dz_q     <= 1'b0;
            x_q      <= {WIDTH{1'b0}};
            y_q      <= {WIDTH{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            zhi_q    <= {WIDTH{1'b0}};
            zlo_q    <= {WIDTH{1'b0}};
        end else begin
            mcnt_q   <= mcnt_d;
            iter_q   <= iter_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            bmag_q   <= bmag_d;
            sign_a_q <= sign_a_d;
            sign_q_q <= sign_q_d;
            dz_q     <= dz_d;
            x_q      <= x_d;
            y_q      <= y_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
            zhi_q    <= zhi_d;
            zlo_q    <= zlo_d;
        end
    end

    assign mul_x       = x_q;
    assign mul_y       = y_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign z_hi        = zhi_q;
    assign z_lo        = zlo_q;

endmodule
